// File: rtl/buffer_write_arbiter_if.sv
// Producer/Buffer side bundle of the buffer write arbiter.
// master: producers + Buffer model; slave: the arbiter.
interface buffer_write_arbiter_if #(
  parameter int DATA_WIDTH = 40,
  parameter int CNT_WIDTH  = 16
);
  logic                  enable;
  logic                  multi_en;
  logic [3:0]            req;
  logic [DATA_WIDTH-1:0] data0;
  logic [DATA_WIDTH-1:0] data1;
  logic [DATA_WIDTH-1:0] data2;
  logic [DATA_WIDTH-1:0] data3;
  logic                  buf_full;
  logic                  buf_in_ready;
  logic                  buf_multi_width;
  logic [DATA_WIDTH-1:0] buf_data0;
  logic [DATA_WIDTH-1:0] buf_data1;
  logic [DATA_WIDTH-1:0] buf_data2;
  logic [DATA_WIDTH-1:0] buf_data3;
  logic [3:0]            ack;
  logic [1:0]            grant_id;
  logic [1:0]            state;
  logic [CNT_WIDTH-1:0]  words_issued;

  modport master (
    output enable, multi_en, req,
    output data0, data1, data2, data3,
    output buf_full,
    input  buf_in_ready, buf_multi_width,
    input  buf_data0, buf_data1, buf_data2, buf_data3,
    input  ack, grant_id, state, words_issued
  );

  modport slave (
    input  enable, multi_en, req,
    input  data0, data1, data2, data3,
    input  buf_full,
    output buf_in_ready, buf_multi_width,
    output buf_data0, buf_data1, buf_data2, buf_data3,
    output ack, grant_id, state, words_issued
  );
endinterface

// File: rtl/buffer_write_arbiter.sv
// Arbitrates four producers onto the Buffer write port:
// round-robin single writes on lane 0, or one 4-lane write.
// Ports: clk, rst (async, active high), bus (slave modport):
//   enable/multi_en/req/data0..3/buf_full in,
//   buf_in_ready/buf_multi_width/buf_data0..3/ack/
//   grant_id/state/words_issued out (all registered).
module buffer_write_arbiter #(
  parameter int DATA_WIDTH = 40,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  buffer_write_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2,
    OFF   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            ptr_q, ptr_d;
  logic                  vld_q, vld_d;
  logic                  mw_q, mw_d;
  logic [DATA_WIDTH-1:0] bd0_q, bd0_d;
  logic [DATA_WIDTH-1:0] bd1_q, bd1_d;
  logic [DATA_WIDTH-1:0] bd2_q, bd2_d;
  logic [DATA_WIDTH-1:0] bd3_q, bd3_d;
  logic [3:0]            ack_q, ack_d;
  logic [1:0]            gid_q, gid_d;
  logic [CNT_WIDTH-1:0]  words_q, words_d;

  logic [3:0]            eff;
  logic                  multi_go;
  logic [1:0]            sel;
  logic                  found;
  logic [DATA_WIDTH-1:0] din [4];

  // Lanes acked this cycle are still holding their old
  // request; mask them so a word is never issued twice.
  assign eff = bus.req & ~ack_q;

  assign din[0] = bus.data0;
  assign din[1] = bus.data1;
  assign din[2] = bus.data2;
  assign din[3] = bus.data3;

  // First requester after the pointer, wrapping; k=4
  // revisits the pointer lane itself last.
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && eff[ptr_q + 2'(k)]) begin
        sel   = ptr_q + 2'(k);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      vld_q   <= 1'b0;
      mw_q    <= 1'b0;
      bd0_q   <= '0;
      bd1_q   <= '0;
      bd2_q   <= '0;
      bd3_q   <= '0;
      ack_q   <= '0;
      gid_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      mw_q    <= mw_d;
      bd0_q   <= bd0_d;
      bd1_q   <= bd1_d;
      bd2_q   <= bd2_d;
      bd3_q   <= bd3_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
      words_q <= words_d;
    end
  end

  // Disable outranks a full Buffer.
  always_comb begin
    state_d = IDLE;
    if (!bus.enable)
      state_d = OFF;
    else if (bus.buf_full)
      state_d = (eff != 4'd0) ? STALL : IDLE;
    else if (eff != 4'd0)
      state_d = ISSUE;
  end

  assign multi_go = bus.multi_en && (eff == 4'hF);

  always_comb begin
    vld_d   = 1'b0;
    mw_d    = 1'b0;
    bd0_d   = '0;
    bd1_d   = '0;
    bd2_d   = '0;
    bd3_d   = '0;
    ack_d   = '0;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    words_d = words_q;
    if (state_d == ISSUE) begin
      vld_d = 1'b1;
      if (multi_go) begin
        mw_d    = 1'b1;
        bd0_d   = bus.data0;
        bd1_d   = bus.data1;
        bd2_d   = bus.data2;
        bd3_d   = bus.data3;
        ack_d   = 4'hF;
        words_d = words_q + CNT_WIDTH'(4);
      end else begin
        bd0_d      = din[sel];
        ack_d[sel] = 1'b1;
        ptr_d      = sel;
        gid_d      = sel;
        words_d    = words_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.buf_in_ready    = vld_q;
  assign bus.buf_multi_width = mw_q;
  assign bus.buf_data0       = bd0_q;
  assign bus.buf_data1       = bd1_q;
  assign bus.buf_data2       = bd2_q;
  assign bus.buf_data3       = bd3_q;
  assign bus.ack             = ack_q;
  assign bus.grant_id        = gid_q;
  assign bus.state           = state_q;
  assign bus.words_issued    = words_q;
endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Scoreboard bench for buffer_write_arbiter: a reference
// model pushes per-cycle expectations, a monitor checks.
module tb_buffer_write_arbiter;
  localparam int DW = 40;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buffer_write_arbiter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus();

  buffer_write_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic          vld;
    logic          mw;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] d3;
    logic [3:0]    ack;
    logic [1:0]    gid;
    logic [1:0]    st;
    logic [CW-1:0] words;
  } exp_t;

  exp_t q[$];
  int total  = 0;
  int passed = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Reference model: the spec's decision rules in plain form.
  int            m_ptr;
  logic [3:0]    m_ack;
  logic [1:0]    m_gid;
  logic [CW-1:0] m_words;

  function automatic logic [DW-1:0] pdata(int i);
    case (i)
      0: return bus.data0;
      1: return bus.data1;
      2: return bus.data2;
      default: return bus.data3;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr   = 3;
      m_ack   = 4'd0;
      m_gid   = 2'd0;
      m_words = '0;
      q.delete();
    end else begin
      exp_t       e;
      logic [3:0] eff;
      int         s;
      e = '{default: 0};
      eff = bus.req & ~m_ack;
      if (!bus.enable) begin
        e.st = 2'd3;
      end else if (bus.buf_full) begin
        e.st = (eff != 0) ? 2'd2 : 2'd0;
      end else if (bus.multi_en && eff == 4'hF) begin
        e.st  = 2'd1;
        e.vld = 1'b1;
        e.mw  = 1'b1;
        e.d0  = bus.data0;
        e.d1  = bus.data1;
        e.d2  = bus.data2;
        e.d3  = bus.data3;
        e.ack = 4'hF;
        m_words = m_words + 4;
      end else if (eff != 0) begin
        s = -1;
        for (int k = 1; k <= 4; k++)
          if (s < 0 && eff[(m_ptr + k) % 4]) s = (m_ptr + k) % 4;
        e.st   = 2'd1;
        e.vld  = 1'b1;
        e.d0   = pdata(s);
        e.ack  = 4'd1 << s;
        m_ptr  = s;
        m_gid  = 2'(s);
        m_words = m_words + 1;
      end
      m_ack   = e.ack;
      e.gid   = m_gid;
      e.words = m_words;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ready", 64'(bus.buf_in_ready), 64'(e.vld));
      chk("ack", 64'(bus.ack), 64'(e.ack));
      chk("state", 64'(bus.state), 64'(e.st));
      chk("words", 64'(bus.words_issued), 64'(e.words));
      chk("grant_id", 64'(bus.grant_id), 64'(e.gid));
      if (e.vld || bus.buf_in_ready) begin
        chk("multi", 64'(bus.buf_multi_width), 64'(e.mw));
        chk("data0", 64'(bus.buf_data0), 64'(e.d0));
        chk("data1", 64'(bus.buf_data1), 64'(e.d1));
        chk("data2", 64'(bus.buf_data2), 64'(e.d2));
        chk("data3", 64'(bus.buf_data3), 64'(e.d3));
      end
    end else if (rst) begin
      chk("rst_ready", 64'(bus.buf_in_ready), 64'd0);
      chk("rst_state", 64'(bus.state), 64'd0);
      chk("rst_words", 64'(bus.words_issued), 64'd0);
      chk("rst_ack", 64'(bus.ack), 64'd0);
    end
  end

  task automatic set_data(int i, logic [DW-1:0] v);
    case (i)
      0: bus.data0 = v;
      1: bus.data1 = v;
      2: bus.data2 = v;
      default: bus.data3 = v;
    endcase
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {8'($urandom), $urandom};
  endfunction

  // One producer cycle: react to acks, maybe raise new reqs.
  task automatic step(int p_keep, int p_new, bit hold0);
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (bus.ack[i]) begin
        if (hold0 && i == 0) begin
        end else if (int'($urandom_range(99)) < p_keep) begin
          set_data(i, rnd_data());
        end else begin
          bus.req[i] = 1'b0;
        end
      end else if (!bus.req[i] && int'($urandom_range(99)) < p_new) begin
        bus.req[i] = 1'b1;
        set_data(i, rnd_data());
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    bus.enable   = 1'b1;
    bus.multi_en = 1'b0;
    bus.req      = 4'd0;
    bus.data0    = '0;
    bus.data1    = '0;
    bus.data2    = '0;
    bus.data3    = '0;
    bus.buf_full = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(10);

    // round-robin single issues 0,1,2,3,0
    bus.data0 = 40'h11;
    bus.data1 = 40'h22;
    bus.data2 = 40'h33;
    bus.data3 = 40'h44;
    bus.req   = 4'hF;
    for (int i = 0; i < 6; i++) step(100, 0, 1'b0);
    bus.req = 4'd0;
    idle(3);

    // multi-width issues
    bus.data0 = 40'hA0;
    bus.data1 = 40'hA1;
    bus.data2 = 40'hA2;
    bus.data3 = 40'hA3;
    bus.multi_en = 1'b1;
    bus.req = 4'hF;
    for (int i = 0; i < 5; i++) step(100, 0, 1'b0);
    bus.req = 4'd0;
    bus.multi_en = 1'b0;
    idle(3);

    // stall on full
    bus.data2 = 40'h2222;
    bus.req = 4'b0100;
    bus.buf_full = 1'b1;
    idle(3);
    bus.buf_full = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 1'b0);
    idle(2);

    // lane 0 holds its req: no back-to-back lane 0 issue
    bus.data0 = 40'h1000;
    bus.data1 = 40'h2000;
    bus.req = 4'b0011;
    for (int i = 0; i < 6; i++) step(100, 0, 1'b1);
    bus.req = 4'd0;
    idle(2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(19) == 0) bus.multi_en = ~bus.multi_en;
      bus.enable   = ($urandom_range(9) != 0);
      bus.buf_full = ($urandom_range(4) == 0);
      step(60, 40, 1'b0);
    end
    bus.enable   = 1'b1;
    bus.buf_full = 1'b0;
    bus.multi_en = 1'b0;
    bus.req      = 4'd0;
    idle(3);

    // async reset while a write is presented
    bus.req = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(100, 0, 1'b0);
      seen = bus.buf_in_ready;
    end
    chk("wait_ready", 64'(seen), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_ready", 64'(bus.buf_in_ready), 64'd0);
    chk("async_ack", 64'(bus.ack), 64'd0);
    chk("async_words", 64'(bus.words_issued), 64'd0);
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(100, 0, 1'b0);
    bus.req = 4'd0;
    idle(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
